// File: rtl/rtl_constants.sv
// Shared front-end constants: rename widths plus reorder buffer sizing and entry layout.
package rtl_constants;

  // Rename / issue widths
  localparam int ISSUE_WIDTH_MAX = 2;
  localparam int SRC_LEN         = 5;
  localparam int XLEN            = 32;

  // Reorder buffer sizing
  localparam int ROB_SIZE        = 16;
  localparam int ROB_SIZE_CLOG   = 4;
  localparam int ROB_MAX_RETIRE  = 2;
  localparam int NUM_WB          = 2;

  // Occupancy counter must hold 0..ROB_SIZE inclusive
  localparam int ROB_CNT_W       = ROB_SIZE_CLOG + 1;

  typedef logic [ROB_SIZE_CLOG-1:0] robid_t;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic               mispredict;
    logic               no_rd;
    logic [SRC_LEN-1:0] rd;
    logic [XLEN-1:0]    data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire-slot qualification over the head window. A slot retires only if every
// older slot in the window retires and no older retiring slot is a mispredict,
// so at most one mispredict can retire per cycle and it is always the youngest retiree.
module rob_retire_sel
  import rtl_constants::*;
(
  input  rob_entry_t                win [ROB_MAX_RETIRE],
  output logic [ROB_MAX_RETIRE-1:0] ret,
  output logic                      flush,
  output robid_t                    flush_off
);

  // In-order qualification chain with mispredict cut
  always_comb begin
    logic chain_ok;
    logic [ROB_MAX_RETIRE-1:0] sel;
    chain_ok  = 1'b1;
    sel       = '0;
    flush     = 1'b0;
    flush_off = '0;
    for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
      sel[i] = chain_ok && win[i].valid && win[i].done;
      if (sel[i] && win[i].mispredict && !flush) begin
        flush     = 1'b1;
        flush_off = robid_t'(i);
      end
      chain_ok = sel[i] && !win[i].mispredict;
    end
    ret = sel;
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocation from rename, out-of-order completion from
// writeback, in-order retirement with flush on a retiring mispredicted branch.
// Allocation contract: rename may assert instr_val_id at any time; the request is
// accepted in full that cycle iff rob_full is low and no flush is being taken,
// otherwise it is dropped entirely (there is no stall/retry handshake).
module rob
  import rtl_constants::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]                instr_val_id,
  input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]   rd_id,
  input  logic [ISSUE_WIDTH_MAX-1:0]                branch_id,
  input  logic [ISSUE_WIDTH_MAX-1:0]                store_id,
  output logic [ROB_SIZE_CLOG-1:0]                  rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]                  rob_is_ptr_p1,
  output logic                                      rob_full,
  input  logic [NUM_WB-1:0]                         wb_val,
  input  logic [NUM_WB-1:0][ROB_SIZE_CLOG-1:0]      wb_robid,
  input  logic [NUM_WB-1:0][XLEN-1:0]               wb_data,
  input  logic [NUM_WB-1:0]                         wb_mispredict,
  output logic [ROB_MAX_RETIRE-1:0]                 val_ret,
  output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]    rd_ret,
  output logic [ROB_MAX_RETIRE-1:0][XLEN-1:0]       data_ret,
  output logic [ROB_MAX_RETIRE-1:0]                 branch_ret,
  output logic                                      branch_clear_id,
  output logic [ROB_SIZE_CLOG-1:0]                  mispredict_tag_id
);

  rob_entry_t                 entries [ROB_SIZE];
  robid_t                     head;
  robid_t                     tail;
  logic [ROB_CNT_W-1:0]       count;

  rob_entry_t                 win [ROB_MAX_RETIRE];
  logic [ROB_MAX_RETIRE-1:0]  ret;
  logic                       flush;
  robid_t                     flush_off;

  logic [ROB_CNT_W-1:0]       num_ret;
  logic [ROB_CNT_W-1:0]       num_alloc;
  logic [ROB_CNT_W-1:0]       count_next;
  robid_t                     head_next;
  logic                       alloc_ok;
  robid_t                     slot_idx [ISSUE_WIDTH_MAX];

  assign rob_full      = count > ROB_CNT_W'(ROB_SIZE - ISSUE_WIDTH_MAX);
  assign rob_is_ptr    = tail;
  assign rob_is_ptr_p1 = tail + robid_t'(1);

  // Head window presented to the retire selector
  always_comb begin
    for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
      win[i] = entries[head + robid_t'(i)];
    end
  end

  rob_retire_sel u_retire_sel (
    .win       (win),
    .ret       (ret),
    .flush     (flush),
    .flush_off (flush_off)
  );

  // Pointer and occupancy bookkeeping; each allocating slot takes tail plus the
  // number of lower allocating slots, so a lone slot 1 lands on tail
  always_comb begin
    num_ret = '0;
    for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
      num_ret = num_ret + ROB_CNT_W'(ret[i]);
    end
    head_next = head + num_ret[ROB_SIZE_CLOG-1:0];
    alloc_ok  = !rob_full && !flush;
    num_alloc = '0;
    for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
      slot_idx[s] = tail + num_alloc[ROB_SIZE_CLOG-1:0];
      if (alloc_ok && instr_val_id[s]) begin
        num_alloc = num_alloc + ROB_CNT_W'(1);
      end
    end
    count_next = flush ? '0 : (count + num_alloc - num_ret);
  end

  // Entry array, pointers and registered retire/flush outputs; later writes in
  // this block win, so retire clear and flush override writeback on the same entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      val_ret           <= '0;
      rd_ret            <= '0;
      data_ret          <= '0;
      branch_ret        <= '0;
      branch_clear_id   <= 1'b0;
      mispredict_tag_id <= '0;
    end else begin
      for (int w = 0; w < NUM_WB; w++) begin
        if (wb_val[w] && entries[wb_robid[w]].valid) begin
          entries[wb_robid[w]].done       <= 1'b1;
          entries[wb_robid[w]].data       <= wb_data[w];
          entries[wb_robid[w]].mispredict <= wb_mispredict[w];
        end
      end
      for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
        if (alloc_ok && instr_val_id[s]) begin
          entries[slot_idx[s]] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                    no_rd: branch_id[s] | store_id[s],
                                    rd: rd_id[s], data: '0};
        end
      end
      for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
        if (ret[i]) begin
          entries[head + robid_t'(i)] <= '0;
        end
        val_ret[i]    <= ret[i];
        rd_ret[i]     <= ret[i] ? win[i].rd : '0;
        data_ret[i]   <= ret[i] ? win[i].data : '0;
        branch_ret[i] <= ret[i] & win[i].no_rd;
      end
      if (flush) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          entries[i] <= '0;
        end
        mispredict_tag_id <= head + flush_off;
      end
      branch_clear_id <= flush;
      head            <= head_next;
      tail            <= flush ? head_next : (tail + num_alloc[ROB_SIZE_CLOG-1:0]);
      count           <= count_next;
    end
  end

  // Two writeback ports naming the same entry in one cycle is illegal
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < NUM_WB; a++) begin
        for (int b = a + 1; b < NUM_WB; b++) begin
          assert (!(wb_val[a] && wb_val[b] && (wb_robid[a] == wb_robid[b])));
        end
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: table of per-cycle vectors for the basic flow, then
// hand-written sequences for reset, full/wrap and mispredict flush.
module tb_rob;
  import rtl_constants::*;

  logic                                    clk = 1'b0;
  logic                                    rst;
  logic [ISSUE_WIDTH_MAX-1:0]              instr_val_id;
  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0] rd_id;
  logic [ISSUE_WIDTH_MAX-1:0]              branch_id;
  logic [ISSUE_WIDTH_MAX-1:0]              store_id;
  logic [ROB_SIZE_CLOG-1:0]                rob_is_ptr;
  logic [ROB_SIZE_CLOG-1:0]                rob_is_ptr_p1;
  logic                                    rob_full;
  logic [NUM_WB-1:0]                       wb_val;
  logic [NUM_WB-1:0][ROB_SIZE_CLOG-1:0]    wb_robid;
  logic [NUM_WB-1:0][XLEN-1:0]             wb_data;
  logic [NUM_WB-1:0]                       wb_mispredict;
  logic [ROB_MAX_RETIRE-1:0]               val_ret;
  logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]  rd_ret;
  logic [ROB_MAX_RETIRE-1:0][XLEN-1:0]     data_ret;
  logic [ROB_MAX_RETIRE-1:0]               branch_ret;
  logic                                    branch_clear_id;
  logic [ROB_SIZE_CLOG-1:0]                mispredict_tag_id;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DB = 32'hD000_0000;

  rob dut (
    .clk               (clk),
    .rst               (rst),
    .instr_val_id      (instr_val_id),
    .rd_id             (rd_id),
    .branch_id         (branch_id),
    .store_id          (store_id),
    .rob_is_ptr        (rob_is_ptr),
    .rob_is_ptr_p1     (rob_is_ptr_p1),
    .rob_full          (rob_full),
    .wb_val            (wb_val),
    .wb_robid          (wb_robid),
    .wb_data           (wb_data),
    .wb_mispredict     (wb_mispredict),
    .val_ret           (val_ret),
    .rd_ret            (rd_ret),
    .data_ret          (data_ret),
    .branch_ret        (branch_ret),
    .branch_clear_id   (branch_clear_id),
    .mispredict_tag_id (mispredict_tag_id)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  iv;
    logic [4:0]  rd0, rd1;
    logic [1:0]  wv;
    logic [3:0]  wid0, wid1;
    logic [31:0] wd0, wd1;
    logic [3:0]  e_ptr, e_p1;
    logic        e_full;
    logic [1:0]  e_val;
    logic [4:0]  e_rd0, e_rd1;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vt [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    instr_val_id  = '0;
    rd_id         = '0;
    branch_id     = '0;
    store_id      = '0;
    wb_val        = '0;
    wb_robid      = '0;
    wb_data       = '0;
    wb_mispredict = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_ret(input string name, input logic [1:0] ev, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] br);
    chk({name, "_val"}, 32'(val_ret), 32'(ev));
    chk({name, "_rd0"}, 32'(rd_ret[0]), 32'(r0));
    chk({name, "_rd1"}, 32'(rd_ret[1]), 32'(r1));
    chk({name, "_d0"}, data_ret[0], d0);
    chk({name, "_d1"}, data_ret[1], d1);
    chk({name, "_br"}, 32'(branch_ret), 32'(br));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ptr"}, 32'(rob_is_ptr), 32'd0);
    chk({name, "_p1"}, 32'(rob_is_ptr_p1), 32'd1);
    chk({name, "_full"}, 32'(rob_full), 32'd0);
    chk({name, "_clear"}, 32'(branch_clear_id), 32'd0);
    chk({name, "_tag"}, 32'(mispredict_tag_id), 32'd0);
    chk_ret(name, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
  endtask

  initial begin
    int ra, rb;
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Basic allocate / out-of-order writeback / paired retire / invalid writeback
    vt[0] = '{iv:2'b11, rd0:5'd3, rd1:5'd5, wv:2'b00, wid0:4'd0, wid1:4'd0, wd0:32'h0, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};
    vt[1] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b01, wid0:4'd1, wid1:4'd0, wd0:32'hB1, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};
    vt[2] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b01, wid0:4'd0, wid1:4'd0, wd0:32'hA0, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};
    vt[3] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b00, wid0:4'd0, wid1:4'd0, wd0:32'h0, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b11, e_rd0:5'd3, e_rd1:5'd5, e_d0:32'hA0, e_d1:32'hB1};
    vt[4] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b01, wid0:4'd2, wid1:4'd0, wd0:32'hEE, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};
    vt[5] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b00, wid0:4'd0, wid1:4'd0, wd0:32'h0, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};
    vt[6] = '{iv:2'b00, rd0:5'd0, rd1:5'd0, wv:2'b00, wid0:4'd0, wid1:4'd0, wd0:32'h0, wd1:32'h0,
              e_ptr:4'd2, e_p1:4'd3, e_full:1'b0, e_val:2'b00, e_rd0:5'd0, e_rd1:5'd0, e_d0:32'h0, e_d1:32'h0};

    for (int r = 0; r < 7; r++) begin
      instr_val_id = vt[r].iv;
      rd_id[0]     = vt[r].rd0;
      rd_id[1]     = vt[r].rd1;
      wb_val       = vt[r].wv;
      wb_robid[0]  = vt[r].wid0;
      wb_robid[1]  = vt[r].wid1;
      wb_data[0]   = vt[r].wd0;
      wb_data[1]   = vt[r].wd1;
      tick();
      clr_in();
      chk($sformatf("vec%0d_ptr", r), 32'(rob_is_ptr), 32'(vt[r].e_ptr));
      chk($sformatf("vec%0d_p1", r), 32'(rob_is_ptr_p1), 32'(vt[r].e_p1));
      chk($sformatf("vec%0d_full", r), 32'(rob_full), 32'(vt[r].e_full));
      chk_ret($sformatf("vec%0d", r), vt[r].e_val, vt[r].e_rd0, vt[r].e_rd1, vt[r].e_d0, vt[r].e_d1, 2'b00);
    end

    // Reset with six live entries (robids 2..7), one of them about to retire
    for (int k = 0; k < 3; k++) begin
      instr_val_id = 2'b11;
      rd_id[0] = 5'(10 + 2 * k);
      rd_id[1] = 5'(11 + 2 * k);
      tick();
      clr_in();
      chk("rst_fill_ptr", 32'(rob_is_ptr), 32'(4 + 2 * k));
    end
    wb_val = 2'b01; wb_robid[0] = 4'd2; wb_data[0] = 32'h55;
    tick();
    clr_in();
    chk("rst_pre_val", 32'(val_ret), 32'd0);
    rst = 1'b1;
    instr_val_id = 2'b11; wb_val = 2'b01; wb_robid[0] = 4'd3; wb_data[0] = 32'h66;
    tick();
    clr_in();
    rst = 1'b0;
    chk_reset_outputs("rst_mid");
    tick();
    chk_reset_outputs("rst_after");

    // Fill to 14, then to 15 (full), dropped request, one retire clears full
    for (int k = 0; k < 7; k++) begin
      instr_val_id = 2'b11;
      rd_id[0] = 5'(2 * k + 1);
      rd_id[1] = 5'(2 * k + 2);
      tick();
      clr_in();
      chk("fill_ptr", 32'(rob_is_ptr), 32'((2 * k + 2) % 16));
      chk("fill_full", 32'(rob_full), 32'd0);
    end
    instr_val_id = 2'b01; rd_id[0] = 5'd15;
    tick();
    clr_in();
    chk("full15_ptr", 32'(rob_is_ptr), 32'd15);
    chk("full15_full", 32'(rob_full), 32'd1);
    instr_val_id = 2'b11; rd_id[0] = 5'd30; rd_id[1] = 5'd31;
    tick();
    clr_in();
    chk("full_drop_ptr", 32'(rob_is_ptr), 32'd15);
    chk("full_drop_full", 32'(rob_full), 32'd1);
    wb_val = 2'b01; wb_robid[0] = 4'd0; wb_data[0] = DB;
    tick();
    clr_in();
    chk("full_wb_full", 32'(rob_full), 32'd1);
    chk("full_wb_val", 32'(val_ret), 32'd0);
    tick();
    chk_ret("full_ret", 2'b01, 5'd1, 5'd0, DB, 32'd0, 2'b00);
    chk("full_clear_full", 32'(rob_full), 32'd0);
    // Tail wraps: robids 15 and 0
    instr_val_id = 2'b11; rd_id[0] = 5'd16; rd_id[1] = 5'd1;
    tick();
    clr_in();
    chk("wrap_ptr", 32'(rob_is_ptr), 32'd1);
    chk("wrap_p1", 32'(rob_is_ptr_p1), 32'd2);
    chk("wrap_full", 32'(rob_full), 32'd1);

    // Drain all 16 entries two per cycle; head wraps 15 -> 0
    for (int c = 0; c < 8; c++) begin
      ra = (1 + 2 * c) % 16;
      rb = (2 + 2 * c) % 16;
      wb_val = 2'b11;
      wb_robid[0] = 4'(ra); wb_data[0] = DB + 32'(ra);
      wb_robid[1] = 4'(rb); wb_data[1] = DB + 32'(rb);
      tick();
      clr_in();
      if (c == 0) begin
        chk("drain_first_val", 32'(val_ret), 32'd0);
      end else begin
        ra = (2 * c - 1) % 16;
        rb = (2 * c) % 16;
        chk_ret($sformatf("drain%0d", c), 2'b11, 5'(ra + 1), 5'(rb + 1), DB + 32'(ra), DB + 32'(rb), 2'b00);
      end
    end
    tick();
    chk_ret("drain_wrap", 2'b11, 5'd16, 5'd1, DB + 32'd15, DB, 2'b00);
    tick();
    chk("drain_idle_val", 32'(val_ret), 32'd0);
    chk("drain_idle_ptr", 32'(rob_is_ptr), 32'd1);
    chk("drain_idle_full", 32'(rob_full), 32'd0);

    // Mispredicted branch at robid 4 with robid 5 already done
    instr_val_id = 2'b11; rd_id[0] = 5'd2; rd_id[1] = 5'd3;
    tick(); clr_in();
    instr_val_id = 2'b01; rd_id[0] = 5'd4;
    tick(); clr_in();
    instr_val_id = 2'b11; branch_id = 2'b01; rd_id[0] = 5'd5; rd_id[1] = 5'd6;
    tick(); clr_in();
    chk("mp_alloc_ptr", 32'(rob_is_ptr), 32'd6);
    wb_val = 2'b11; wb_robid[0] = 4'd1; wb_data[0] = DB + 32'd1; wb_robid[1] = 4'd2; wb_data[1] = DB + 32'd2;
    tick(); clr_in();
    chk("mp_wb12_val", 32'(val_ret), 32'd0);
    wb_val = 2'b01; wb_robid[0] = 4'd3; wb_data[0] = DB + 32'd3;
    tick(); clr_in();
    chk_ret("mp_ret12", 2'b11, 5'd2, 5'd3, DB + 32'd1, DB + 32'd2, 2'b00);
    wb_val = 2'b01; wb_robid[0] = 4'd5; wb_data[0] = DB + 32'd5;
    tick(); clr_in();
    chk_ret("mp_ret3", 2'b01, 5'd4, 5'd0, DB + 32'd3, 32'd0, 2'b00);
    wb_val = 2'b01; wb_robid[0] = 4'd4; wb_data[0] = DB + 32'd4; wb_mispredict = 2'b01;
    tick(); clr_in();
    chk_ret("mp_wb4", 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
    chk("mp_wb4_clear", 32'(branch_clear_id), 32'd0);
    instr_val_id = 2'b11; rd_id[0] = 5'd20; rd_id[1] = 5'd21;
    tick(); clr_in();
    chk_ret("mp_flush", 2'b01, 5'd5, 5'd0, DB + 32'd4, 32'd0, 2'b01);
    chk("mp_flush_clear", 32'(branch_clear_id), 32'd1);
    chk("mp_flush_tag", 32'(mispredict_tag_id), 32'd4);
    chk("mp_flush_ptr", 32'(rob_is_ptr), 32'd5);
    chk("mp_flush_full", 32'(rob_full), 32'd0);
    tick();
    chk("mp_post_val", 32'(val_ret), 32'd0);
    chk("mp_post_clear", 32'(branch_clear_id), 32'd0);
    chk("mp_post_tag", 32'(mispredict_tag_id), 32'd4);
    chk("mp_post_ptr", 32'(rob_is_ptr), 32'd5);
    instr_val_id = 2'b01; rd_id[0] = 5'd7;
    tick(); clr_in();
    chk("mp_realloc_ptr", 32'(rob_is_ptr), 32'd6);
    wb_val = 2'b01; wb_robid[0] = 4'd5; wb_data[0] = 32'h77;
    tick(); clr_in();
    chk("mp_realloc_wb_val", 32'(val_ret), 32'd0);
    tick();
    chk_ret("mp_realloc_ret", 2'b01, 5'd7, 5'd0, 32'h77, 32'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer feeding the front-end rename table and fed by the writeback buses. Allocates up to two in-order entries per cycle for renamed instructions and exposes the allocation pointer and full flag to rename. Collects completion results and retires up to two completed entries per cycle in program order on the retire bus. On retirement of a mispredicted branch it flushes all younger entries and signals rename.

## Interface
Parameters:
- ISSUE_WIDTH_MAX, 2, allocation slots per cycle
- ROB_SIZE, 16, entries (power of two)
- ROB_SIZE_CLOG, 4, log2(ROB_SIZE)
- ROB_MAX_RETIRE, 2, retire slots per cycle
- NUM_WB, 2, writeback ports
- SRC_LEN, 5, architectural register index width
- XLEN, 32, result width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr_val_id  in  ISSUE_WIDTH_MAX  allocation request per slot
- rd_id  in  ISSUE_WIDTH_MAX x SRC_LEN  destination register
- branch_id  in  ISSUE_WIDTH_MAX  slot is a branch (no rd write)
- store_id  in  ISSUE_WIDTH_MAX  slot is a store (no rd write)
- rob_is_ptr  out  ROB_SIZE_CLOG  robid for the first valid allocating slot (tail)
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  tail+1 mod ROB_SIZE
- rob_full  out  1  fewer than ISSUE_WIDTH_MAX free entries
- wb_val  in  NUM_WB  writeback valid
- wb_robid  in  NUM_WB x ROB_SIZE_CLOG  entry completed
- wb_data  in  NUM_WB x XLEN  result
- wb_mispredict  in  NUM_WB  branch resolved mispredicted
- val_ret  out  ROB_MAX_RETIRE  retire slot valid
- rd_ret  out  ROB_MAX_RETIRE x SRC_LEN  retiring rd
- data_ret  out  ROB_MAX_RETIRE x XLEN  retiring result
- branch_ret  out  ROB_MAX_RETIRE  retiring entry has no rd write (branch or store)
- branch_clear_id  out  1  flush pulse
- mispredict_tag_id  out  ROB_SIZE_CLOG  robid of the mispredicted branch

## Operation
- Entry state: valid, done, mispredict, no_rd, rd, data.
- Allocation is all-or-nothing. When rob_full=1 or a flush is being taken this cycle, nothing is allocated.
- Otherwise each valid slot gets tail + (number of lower valid slots). An entry is written valid=1, done=0, and tail advances by popcount(instr_val_id).
- Slot 1 alone takes rob_is_ptr, which matches rename's use of rob_is_ptr_p1 only when slot 0 is valid.
- Writeback sets done, data and mispredict when the addressed entry is valid; writeback to an invalid entry is ignored.
- Two ports addressing the same robid in one cycle is illegal. It is asserted in simulation, and the higher port index wins.
- Retire selection (combinational, from head):
  - Slot 0 retires if entry[head] is valid and done.
  - Slot 1 retires if slot 0 retires, entry[head+1] is valid and done, and entry[head] is not a mispredict.
- Retired entries are cleared, and head advances by the number retired.
- Flush happens when a retiring entry has mispredict=1, on the same edge as the retire:
  - all entries are invalidated;
  - tail <= head_next and count <= 0;
  - branch_clear_id <= 1 and mispredict_tag_id <= that robid.
- count_next = count + allocated - retired (zero on flush).
- rob_full = (count > ROB_SIZE - ISSUE_WIDTH_MAX).
- Pointers are ROB_SIZE_CLOG bits and wrap naturally modulo ROB_SIZE.

## Timing
- Reset values:
  - head, tail and count are 0, and all entries are invalid.
  - val_ret, rd_ret, data_ret, branch_ret, branch_clear_id and mispredict_tag_id are 0.
  - rob_is_ptr=0, rob_is_ptr_p1=1, rob_full=0.
- rob_is_ptr, rob_is_ptr_p1 and rob_full are combinational from registered tail/count, so they are stable for the whole cycle.
- Retire outputs and flush are registered. With writeback captured at edge T, val_ret is high in the cycle after edge T+1 at the earliest.
- val_ret and branch_clear_id are single-cycle pulses per retire event.
- Simultaneous allocation and retire in one cycle is legal: the count nets both, and full is re-evaluated the next cycle.
- Flush has priority over allocation in the same cycle; wrong-path requests are dropped.
- rst mid-operation discards all entries at the next edge; no retire or flush pulse is emitted.

## Structure
- rob_entry_t and the ROB_SIZE/ROB_SIZE_CLOG/ROB_MAX_RETIRE/NUM_WB constants go in the shared rtl_constants package alongside the rename constants.
- One sub-module, rob_retire_sel: pure combinational retire-slot qualification and mispredict cut from the head window.

## Test plan
- Reset, then allocate slots 0 and 1 (rd 3, 5) -> rob_is_ptr 0 then 2, count 2, rob_full 0.
- Write back robid 1 then robid 0 -> no retire after robid 1; after robid 0, both retire in one cycle with val_ret=11, rd_ret {5,3}.
- Allocate 15 entries, then request 2 -> rob_full=1 at count 15, no allocation, tail unchanged; one retire clears full the following cycle.
- Tail at 14, allocate 2 then 2 -> robids 14, 15, 0, 1; head wrap on retire is exercised.
- Mispredicted branch at robid 4 retiring in slot 0 with robid 5 done -> only slot 0 retires; branch_clear_id=1, mispredict_tag_id=4; count 0; a same-cycle allocation is dropped.
- Writeback to an invalid robid, and rst asserted with 6 live entries -> no state change in the first case; the second leaves all outputs at reset values and emits no pulses.
